sitcpxg_rx_stream: RTL



---
 rtl/sitcpxg_rx_stream.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sitcpxg_rx_stream.sv
// Receive-buffer engine for the 10GbE SiTCP core: byte-addressed RX RAM, read pointer,
// lane-reordered valid/ready output stream and the receive-buffer clear handshake.
module sitcpxg_rx_stream #(
    parameter int OUT_BYTES  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                   XGMII_CLOCK,
    input  logic                   RSTs,
    input  logic [15:0]            USER_RX_WADR,
    input  logic [7:0]             USER_RX_WENB,
    input  logic [63:0]            USER_RX_WDAT,
    input  logic                   USER_RX_CLR_ENB,
    output logic                   USER_RX_CLR_REQ,
    output logic [15:0]            USER_RX_RADR,
    output logic [15:0]            USER_RX_SIZE,
    input  logic                   RX_CLEAR,
    output logic [8*OUT_BYTES-1:0] RX_DATA,
    output logic                   RX_VALID,
    input  logic                   RX_READY,
    output logic [ADDR_WIDTH:0]    RX_LEVEL,
    output logic                   RX_CLR_BUSY
);

    localparam int AW = ADDR_WIDTH;
    localparam int DW = 8 * OUT_BYTES;
    localparam int Words = 1 << (AW - 3);
    localparam int unsigned RxSize = (1 << AW) - 16;
    localparam logic [AW-1:0] Step = AW'(OUT_BYTES);

    typedef enum logic [1:0] {StIdle, StWait, StReq} clr_state_e;

    logic [63:0]    ram [Words];
    logic [63:0]    ram_q;
    logic [AW-1:0]  wptr_q, rptr_q, fptr_q;
    logic [AW-1:0]  wr_next, fetch_avail;
    logic [AW-4:0]  wr_word;
    logic [3:0]     wr_inc;
    logic           rd_v_q;
    logic [2:0]     rd_lane_q;
    logic           out_v_q, skid_v_q;
    logic [DW-1:0]  out_q, skid_q, beat;
    logic [63:0]    word_shifted;
    logic [1:0]     occ;
    logic           pop, rd_en;
    clr_state_e     clr_st_q;
    logic           clr_req_q, busy_q;
    logic           unused_wadr;

    assign wr_word     = USER_RX_WADR[AW-1:3];
    assign unused_wadr = ^USER_RX_WADR;

    // The lowest-order enabled lane is the highest byte address written this cycle.
    always_comb begin
        wr_inc = 4'd0;
        for (int b = 7; b >= 0; b--) begin
            if (USER_RX_WENB[b]) wr_inc = 4'(8 - b);
        end
    end

    assign wr_next     = {wr_word, 3'b000} + AW'(wr_inc);
    assign fetch_avail = wptr_q - fptr_q;
    assign pop         = out_v_q & RX_READY;
    assign occ         = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_v_q);
    // Credit check keeps in-flight read plus both output entries at most two deep.
    assign rd_en       = (fetch_avail >= Step) && ((occ - 2'(pop)) < 2'd2);

    assign word_shifted = ram_q << {rd_lane_q, 3'b000};
    assign beat         = word_shifted[63 -: DW];

    always_ff @(posedge XGMII_CLOCK) begin
        for (int b = 0; b < 8; b++) begin
            if (USER_RX_WENB[b]) ram[wr_word][8*b +: 8] <= USER_RX_WDAT[8*b +: 8];
        end
        if (rd_en) ram_q <= ram[fptr_q[AW-1:3]];
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            fptr_q    <= '0;
            rd_v_q    <= 1'b0;
            rd_lane_q <= 3'd0;
            out_v_q   <= 1'b0;
            skid_v_q  <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
        end else if (clr_req_q) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            fptr_q   <= '0;
            rd_v_q   <= 1'b0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            out_q    <= '0;
        end else begin
            if (|USER_RX_WENB) wptr_q <= wr_next;
            if (pop) rptr_q <= rptr_q + Step;
            rd_v_q <= rd_en;
            if (rd_en) begin
                rd_lane_q <= fptr_q[2:0];
                fptr_q    <= fptr_q + Step;
            end
            if (pop) begin
                if (skid_v_q) begin
                    out_q    <= skid_q;
                    skid_v_q <= rd_v_q;
                    if (rd_v_q) skid_q <= beat;
                end else if (rd_v_q) begin
                    out_q <= beat;
                end else begin
                    out_v_q <= 1'b0;
                end
            end else if (rd_v_q) begin
                if (!out_v_q) begin
                    out_q   <= beat;
                    out_v_q <= 1'b1;
                end else begin
                    skid_q   <= beat;
                    skid_v_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            clr_st_q  <= StIdle;
            clr_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (clr_st_q)
                StIdle: begin
                    if (RX_CLEAR) begin
                        clr_st_q <= StWait;
                        busy_q   <= 1'b1;
                    end
                end
                StWait: begin
                    if (USER_RX_CLR_ENB) begin
                        clr_st_q  <= StReq;
                        clr_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    clr_st_q  <= StIdle;
                    clr_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: clr_st_q <= StIdle;
            endcase
        end
    end

    assign USER_RX_CLR_REQ = clr_req_q;
    assign USER_RX_RADR    = 16'(rptr_q);
    assign USER_RX_SIZE    = 16'(RxSize);
    assign RX_DATA         = out_q;
    assign RX_VALID        = out_v_q;
    assign RX_LEVEL        = {1'b0, wptr_q - rptr_q};
    assign RX_CLR_BUSY     = busy_q;

endmodule
